coin_acceptor: RTL

//   Upstream stage of the vending FSM. Turns three raw, bouncy, asynchronous coin-slot sensor lines into

---
 rtl/coin_acceptor_pkg.sv | 25 ++
 rtl/coin_acceptor_if.sv | 40 ++++
 rtl/coin_acceptor_debouncer.sv | 42 ++++
 rtl/coin_acceptor.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Coin codes and cent values shared by the coin acceptor slice.
// Optional build macro used by this slice: COIN_ACCEPTOR_TOTAL_EN.
package coin_pkg;

    localparam int CODE_W = 2;

    localparam logic [CODE_W-1:0] COIN_NONE    = 2'd0;
    localparam logic [CODE_W-1:0] COIN_NICKEL  = 2'd1;
    localparam logic [CODE_W-1:0] COIN_DIME    = 2'd2;
    localparam logic [CODE_W-1:0] COIN_QUARTER = 2'd3;

    localparam logic [15:0] CENTS_NICKEL  = 16'd5;
    localparam logic [15:0] CENTS_DIME    = 16'd10;
    localparam logic [15:0] CENTS_QUARTER = 16'd25;

    function automatic logic [15:0] cents_of(input logic [CODE_W-1:0] code);
        case (code)
            COIN_NICKEL:  cents_of = CENTS_NICKEL;
            COIN_DIME:    cents_of = CENTS_DIME;
            COIN_QUARTER: cents_of = CENTS_QUARTER;
            default:      cents_of = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin delivery interface between the acceptor (master) and the vending FSM (slave).
// Build macro COIN_ACCEPTOR_TOTAL_EN adds the running total_cents signal.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          accept_en;
    logic                          Nickel;
    logic                          Dime;
    logic                          Quarter;
    logic                          coin_reject;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [15:0]                   total_cents;
`endif

    modport master (
`ifdef COIN_ACCEPTOR_TOTAL_EN
        output total_cents,
`endif
        input  accept_en,
        output Nickel,
        output Dime,
        output Quarter,
        output coin_reject,
        output fifo_count
    );

    modport slave (
`ifdef COIN_ACCEPTOR_TOTAL_EN
        input  total_cents,
`endif
        output accept_en,
        input  Nickel,
        input  Dime,
        input  Quarter,
        input  coin_reject,
        input  fifo_count
    );

endinterface

// File: rtl/coin_acceptor_debouncer.sv
// One coin slot: 2-FF synchronizer, stability counter, debounced level and
// a one-cycle rise pulse on every accepted 0->1 level change.
module coin_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronize, then flip the level once the sample has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: three debounced slots feed pending flags, a fixed-priority
// arbiter (Quarter > Dime > Nickel) loads a coin queue, and the queue is drained
// into one-cycle Nickel/Dime/Quarter pulses separated by at least MIN_GAP idle cycles.
// Build macro COIN_ACCEPTOR_TOTAL_EN adds a saturating total_cents accumulator.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int MIN_GAP         = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               coin_nickel_raw,
    input  logic               coin_dime_raw,
    input  logic               coin_quarter_raw,
    coin_acceptor_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    logic [2:0]        rise;      // {quarter, dime, nickel}
    logic [2:0]        pend;
    logic [2:0]        grant;
    logic [CODE_W-1:0] grant_code;
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [GAP_W-1:0]  gap_q;
    logic              full;
    logic              push;
    logic              reject;
    logic              pop;
    logic              nickel_q;
    logic              dime_q;
    logic              quarter_q;
    logic              reject_q;

    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_nickel (
        .clk(clk), .reset_n(reset_n), .raw(coin_nickel_raw), .rise(rise[0])
    );
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dime (
        .clk(clk), .reset_n(reset_n), .raw(coin_dime_raw), .rise(rise[1])
    );
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_quarter (
        .clk(clk), .reset_n(reset_n), .raw(coin_quarter_raw), .rise(rise[2])
    );

    // Pick the highest-value pending coin; a full queue turns the grant into a reject.
    always_comb begin
        grant      = '0;
        grant_code = COIN_NONE;
        if (pend[2]) begin
            grant      = 3'b100;
            grant_code = COIN_QUARTER;
        end else if (pend[1]) begin
            grant      = 3'b010;
            grant_code = COIN_DIME;
        end else if (pend[0]) begin
            grant      = 3'b001;
            grant_code = COIN_NICKEL;
        end
        full   = (count_q == CNT_W'(FIFO_DEPTH));
        push   = (|pend) && !full;
        reject = (|pend) && full;
        pop    = (count_q != '0) && bus.accept_en && (gap_q == '0);
    end

    // Pending flags: cleared only for the granted channel, set by fresh rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | rise;
        end
    end

    // Coin queue storage, pointers and occupancy; fullness ignores a same-cycle pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= COIN_NONE;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= grant_code;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered output pulses, reject pulse and inter-pulse gap counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nickel_q  <= 1'b0;
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            reject_q  <= 1'b0;
            gap_q     <= '0;
        end else begin
            nickel_q  <= pop && (mem[rd_ptr] == COIN_NICKEL);
            dime_q    <= pop && (mem[rd_ptr] == COIN_DIME);
            quarter_q <= pop && (mem[rd_ptr] == COIN_QUARTER);
            reject_q  <= reject;
            if (pop) begin
                gap_q <= GAP_W'(MIN_GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [15:0] total_q;
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_q} + {1'b0, cents_of(mem[rd_ptr])};

    // Running total of delivered coins, updated on the pulse edge, saturating at 16'hFFFF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= '0;
        end else if (pop) begin
            total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    assign bus.total_cents = total_q;
`endif

    assign bus.Nickel      = nickel_q;
    assign bus.Dime        = dime_q;
    assign bus.Quarter     = quarter_q;
    assign bus.coin_reject = reject_q;
    assign bus.fifo_count  = count_q;

endmodule
